// File: rtl/bsg_cache_nb_mhu_dma_arbiter.sv
// Round-robin lock arbiter that shares the non-blocking cache DMA command port among MSHR miss handlers.
// Grants in 1 cycle from IDLE; the owner keeps the lock until it drops busy; done pulses are demuxed by MSHR id.

package bsg_cache_nb_dma_pkg;
  typedef enum logic [2:0] {
    e_dma_nop              = 3'd0,
    e_dma_send_refill_addr = 3'd1,
    e_dma_send_evict_addr  = 3'd2,
    e_dma_get_refill_data  = 3'd3,
    e_dma_send_evict_data  = 3'd4
  } dma_cmd_e;
endpackage

module bsg_cache_nb_mhu_dma_arbiter
  import bsg_cache_nb_dma_pkg::*;
#(
  parameter int addr_width_p = 32,
  parameter int mshr_els_p   = 4,
  parameter int watchdog_p   = 1024,
  localparam int lg_mshr_els_lp = (mshr_els_p > 1) ? $clog2(mshr_els_p) : 1
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,

  input  dma_cmd_e [mshr_els_p-1:0]                 mhu_dma_cmd_i,
  input  logic [mshr_els_p-1:0][addr_width_p-1:0]   mhu_dma_addr_i,
  input  logic [mshr_els_p-1:0]                     mhu_req_busy_i,
  output logic [mshr_els_p-1:0]                     mhu_grant_o,
  output logic [mshr_els_p-1:0]                     mhu_dma_done_o,

  output dma_cmd_e                                  dma_cmd_o,
  output logic [addr_width_p-1:0]                   dma_addr_o,
  output logic [lg_mshr_els_lp-1:0]                 dma_mshr_id_o,
  input  logic                                      dma_done_i,
  input  logic [lg_mshr_els_lp-1:0]                 dma_done_id_i,

  output logic                                      hang_o
);

  localparam int hold_w_lp = $clog2(watchdog_p + 1);
  localparam int idx_w_lp  = lg_mshr_els_lp + 1;

  typedef enum logic {
    e_idle,
    e_locked
  } state_e;

  state_e                    r_state;
  logic [lg_mshr_els_lp-1:0] r_rr_ptr;
  logic [lg_mshr_els_lp-1:0] r_owner;
  logic [hold_w_lp-1:0]      r_hold_cnt;
  logic                      r_hang;

  logic [mshr_els_p-1:0]     w_req;
  logic                      w_any_req;
  logic [lg_mshr_els_lp-1:0] w_pick;
  logic [lg_mshr_els_lp-1:0] w_owner_inc;
  logic                      w_release;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < mshr_els_p; i++) begin
      w_req[i] = (mhu_dma_cmd_i[i] != e_dma_nop);
    end
  end

  assign w_any_req = |w_req;

  // Walk downward from the farthest slot so the nearest request at/after rr_ptr wins last.
  always_comb begin
    logic [idx_w_lp-1:0] idx;
    w_pick = r_rr_ptr;
    idx    = '0;
    for (int k = mshr_els_p - 1; k >= 0; k--) begin
      idx = {1'b0, r_rr_ptr} + idx_w_lp'(k);
      if (idx >= idx_w_lp'(mshr_els_p)) begin
        idx = idx - idx_w_lp'(mshr_els_p);
      end
      if (w_req[idx[lg_mshr_els_lp-1:0]]) begin
        w_pick = idx[lg_mshr_els_lp-1:0];
      end
    end
  end

  assign w_owner_inc = (r_owner == lg_mshr_els_lp'(mshr_els_p - 1)) ? '0 : r_owner + 1'b1;
  assign w_release   = (r_state == e_locked) && !mhu_req_busy_i[r_owner];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= e_idle;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_hold_cnt <= '0;
      r_hang     <= 1'b0;
    end else begin
      case (r_state)
        e_idle: begin
          if (w_any_req) begin
            r_owner <= w_pick;
            r_state <= e_locked;
          end
        end
        e_locked: begin
          if (w_release) begin
            r_state    <= e_idle;
            r_rr_ptr   <= w_owner_inc;
            r_hold_cnt <= '0;
          end else if (r_hold_cnt != hold_w_lp'(watchdog_p)) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
            // hang becomes visible in the same cycle the counter reaches the limit
            if (r_hold_cnt == hold_w_lp'(watchdog_p - 1)) begin
              r_hang <= 1'b1;
            end
          end
        end
        default: r_state <= e_idle;
      endcase
    end
  end

  // Owner's command passes straight through; the release cycle is masked to nop.
  always_comb begin
    mhu_grant_o   = '0;
    dma_cmd_o     = e_dma_nop;
    dma_addr_o    = '0;
    dma_mshr_id_o = '0;
    if (r_state == e_locked) begin
      mhu_grant_o[r_owner] = 1'b1;
      dma_mshr_id_o        = r_owner;
      dma_addr_o           = mhu_dma_addr_i[r_owner];
      dma_cmd_o            = w_release ? e_dma_nop : mhu_dma_cmd_i[r_owner];
    end
  end

  always_comb begin
    mhu_dma_done_o = '0;
    for (int i = 0; i < mshr_els_p; i++) begin
      mhu_dma_done_o[i] = dma_done_i && (dma_done_id_i == lg_mshr_els_lp'(i));
    end
  end

  assign hang_o = r_hang;

endmodule

// File: tb/tb_bsg_cache_nb_mhu_dma_arbiter.sv
// Directed bench for the MHU DMA arbiter: a 4-MHU instance with an 8-cycle watchdog
// and a 3-MHU instance for non-power-of-two wrap and out-of-range done ids.
module tb_bsg_cache_nb_mhu_dma_arbiter;
  import bsg_cache_nb_dma_pkg::*;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  dma_cmd_e [3:0]        cmd4;
  logic [3:0][31:0]      addr4;
  logic [3:0]            busy4;
  logic [3:0]            grant4;
  logic [3:0]            done4;
  dma_cmd_e              ocmd4;
  logic [31:0]           oaddr4;
  logic [1:0]            oid4;
  logic                  ddone4;
  logic [1:0]            did4;
  logic                  hang4;

  dma_cmd_e [2:0]        cmd3;
  logic [2:0][15:0]      addr3;
  logic [2:0]            busy3;
  logic [2:0]            grant3;
  logic [2:0]            done3;
  dma_cmd_e              ocmd3;
  logic [15:0]           oaddr3;
  logic [1:0]            oid3;
  logic                  ddone3;
  logic [1:0]            did3;
  logic                  hang3;

  int checks = 0;
  int errors = 0;

  bsg_cache_nb_mhu_dma_arbiter #(.addr_width_p(32), .mshr_els_p(4), .watchdog_p(8)) u_dut4 (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .mhu_dma_cmd_i(cmd4), .mhu_dma_addr_i(addr4), .mhu_req_busy_i(busy4),
    .mhu_grant_o(grant4), .mhu_dma_done_o(done4),
    .dma_cmd_o(ocmd4), .dma_addr_o(oaddr4), .dma_mshr_id_o(oid4),
    .dma_done_i(ddone4), .dma_done_id_i(did4), .hang_o(hang4)
  );

  bsg_cache_nb_mhu_dma_arbiter #(.addr_width_p(16), .mshr_els_p(3), .watchdog_p(1024)) u_dut3 (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .mhu_dma_cmd_i(cmd3), .mhu_dma_addr_i(addr3), .mhu_req_busy_i(busy3),
    .mhu_grant_o(grant3), .mhu_dma_done_o(done3),
    .dma_cmd_o(ocmd3), .dma_addr_o(oaddr3), .dma_mshr_id_o(oid3),
    .dma_done_i(ddone3), .dma_done_id_i(did3), .hang_o(hang3)
  );

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin cmd4[i] = e_dma_nop; addr4[i] = '0; end
    for (int i = 0; i < 3; i++) begin cmd3[i] = e_dma_nop; addr3[i] = '0; end
    busy4 = '0; ddone4 = 1'b0; did4 = '0;
    busy3 = '0; ddone3 = 1'b0; did3 = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset_n_i = 1'b0;
    step();
    step();
    reset_n_i = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n_i = 1'b0;
    cmd4[1] = e_dma_send_refill_addr; addr4[1] = 32'hDEAD_0000; busy4[1] = 1'b1;
    step(); step();
    checks++; if (grant4 !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected %b", grant4, 4'b0000); end
    checks++; if (ocmd4 !== e_dma_nop) begin errors++; $display("FAIL reset_cmd: got %0d expected %0d", ocmd4, e_dma_nop); end
    checks++; if (oaddr4 !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected %h", oaddr4, 32'h0); end
    checks++; if (oid4 !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", oid4); end
    checks++; if (done4 !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b expected 0000", done4); end
    checks++; if (hang4 !== 1'b0) begin errors++; $display("FAIL reset_hang: got %b expected 0", hang4); end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    cmd4[2] = e_dma_send_refill_addr; addr4[2] = 32'h0000_1000; busy4[2] = 1'b1;
    #1;
    checks++; if (grant4 !== 4'b0000) begin errors++; $display("FAIL single_idle_grant: got %b expected 0000", grant4); end
    checks++; if (ocmd4 !== e_dma_nop) begin errors++; $display("FAIL single_idle_cmd: got %0d expected %0d", ocmd4, e_dma_nop); end
    step();
    checks++; if (grant4 !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", grant4); end
    checks++; if (ocmd4 !== e_dma_send_refill_addr) begin errors++; $display("FAIL single_cmd: got %0d expected %0d", ocmd4, e_dma_send_refill_addr); end
    checks++; if (oaddr4 !== 32'h0000_1000) begin errors++; $display("FAIL single_addr: got %h expected 00001000", oaddr4); end
    checks++; if (oid4 !== 2'd2) begin errors++; $display("FAIL single_id: got %0d expected 2", oid4); end
    cmd4[2] = e_dma_nop; busy4[2] = 1'b0;
    #1;
    checks++; if (ocmd4 !== e_dma_nop) begin errors++; $display("FAIL single_release_cmd: got %0d expected %0d", ocmd4, e_dma_nop); end
    step();
    checks++; if (grant4 !== 4'b0000) begin errors++; $display("FAIL single_back_idle: got %b expected 0000", grant4); end
    // rr_ptr is now 3, so MHU3 must beat MHU0
    cmd4[0] = e_dma_send_refill_addr; busy4[0] = 1'b1;
    cmd4[3] = e_dma_send_evict_addr; addr4[3] = 32'h0000_3000; busy4[3] = 1'b1;
    step();
    checks++; if (grant4 !== 4'b1000) begin errors++; $display("FAIL single_rr_next: got %b expected 1000", grant4); end
    checks++; if (oaddr4 !== 32'h0000_3000) begin errors++; $display("FAIL single_rr_addr: got %h expected 00003000", oaddr4); end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      cmd4[i] = e_dma_get_refill_data; addr4[i] = 32'h100 * i;
    end
    busy4 = 4'hF;
    for (int n = 0; n < 5; n++) begin
      exp = 4'b0001 << order[n];
      step();
      checks++; if (grant4 !== exp) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", n, grant4, exp); end
      checks++; if (oid4 !== 2'(order[n])) begin errors++; $display("FAIL rr_id_%0d: got %0d expected %0d", n, oid4, order[n]); end
      step();
      checks++; if (grant4 !== exp) begin errors++; $display("FAIL rr_hold_%0d: got %b expected %b", n, grant4, exp); end
      step();
      busy4[order[n]] = 1'b0;
      #1;
      checks++; if (ocmd4 !== e_dma_nop) begin errors++; $display("FAIL rr_release_cmd_%0d: got %0d expected %0d", n, ocmd4, e_dma_nop); end
      step();
      checks++; if (grant4 !== 4'b0000) begin errors++; $display("FAIL rr_idle_gap_%0d: got %b expected 0000", n, grant4); end
      busy4 = 4'hF;
    end
  endtask

  task automatic test_lock_hold();
    apply_reset();
    cmd4[1] = e_dma_send_refill_addr; busy4[1] = 1'b1;
    step();
    checks++; if (grant4 !== 4'b0010) begin errors++; $display("FAIL hold_grant: got %b expected 0010", grant4); end
    cmd4[1] = e_dma_nop;
    cmd4[3] = e_dma_send_refill_addr; busy4[3] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (grant4 !== 4'b0010) begin errors++; $display("FAIL hold_grant_%0d: got %b expected 0010", c, grant4); end
      checks++; if (ocmd4 !== e_dma_nop) begin errors++; $display("FAIL hold_cmd_%0d: got %0d expected %0d", c, ocmd4, e_dma_nop); end
    end
    cmd4[1] = e_dma_send_evict_addr; addr4[1] = 32'h0000_ABC0;
    #1;
    checks++; if (ocmd4 !== e_dma_send_evict_addr) begin errors++; $display("FAIL hold_evict_cmd: got %0d expected %0d", ocmd4, e_dma_send_evict_addr); end
    checks++; if (oaddr4 !== 32'h0000_ABC0) begin errors++; $display("FAIL hold_evict_addr: got %h expected 0000abc0", oaddr4); end
    step();
    cmd4[1] = e_dma_nop; busy4[1] = 1'b0;
    step();
    step();
    checks++; if (grant4 !== 4'b1000) begin errors++; $display("FAIL hold_next_owner: got %b expected 1000", grant4); end
  endtask

  task automatic test_done_demux();
    apply_reset();
    cmd4[0] = e_dma_send_refill_addr; busy4[0] = 1'b1;
    step();
    checks++; if (grant4 !== 4'b0001) begin errors++; $display("FAIL done_owner: got %b expected 0001", grant4); end
    ddone4 = 1'b1; did4 = 2'd3;
    #1;
    checks++; if (done4 !== 4'b1000) begin errors++; $display("FAIL done_nonowner: got %b expected 1000", done4); end
    did4 = 2'd0;
    #1;
    checks++; if (done4 !== 4'b0001) begin errors++; $display("FAIL done_owner_id: got %b expected 0001", done4); end
    ddone4 = 1'b0;
    #1;
    checks++; if (done4 !== 4'b0000) begin errors++; $display("FAIL done_idle_low: got %b expected 0000", done4); end
    cmd4[0] = e_dma_nop; busy4[0] = 1'b0;
    step();
    ddone4 = 1'b1; did4 = 2'd1;
    #1;
    checks++; if (done4 !== 4'b0010) begin errors++; $display("FAIL done_unlocked: got %b expected 0010", done4); end
    ddone4 = 1'b0;
    ddone3 = 1'b1; did3 = 2'd3;
    #1;
    checks++; if (done3 !== 3'b000) begin errors++; $display("FAIL done_out_of_range: got %b expected 000", done3); end
    did3 = 2'd2;
    #1;
    checks++; if (done3 !== 3'b100) begin errors++; $display("FAIL done3_id2: got %b expected 100", done3); end
    ddone3 = 1'b0;
  endtask

  task automatic test_watchdog();
    apply_reset();
    cmd4[1] = e_dma_send_refill_addr; busy4[1] = 1'b1;
    step();
    for (int c = 1; c <= 10; c++) begin
      checks++; if (hang4 !== (c >= 9)) begin errors++; $display("FAIL wd_cycle_%0d: got %b expected %b", c, hang4, (c >= 9)); end
      step();
    end
    busy4[1] = 1'b0; cmd4[1] = e_dma_nop;
    #1;
    checks++; if (hang4 !== 1'b1) begin errors++; $display("FAIL wd_release: got %b expected 1", hang4); end
    step();
    step();
    checks++; if (hang4 !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b expected 1", hang4); end
    checks++; if (grant4 !== 4'b0000) begin errors++; $display("FAIL wd_idle: got %b expected 0000", grant4); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 1; i < 4; i++) begin cmd4[i] = e_dma_send_refill_addr; busy4[i] = 1'b1; end
    step();
    checks++; if (grant4 !== 4'b0010) begin errors++; $display("FAIL ar_first: got %b expected 0010", grant4); end
    busy4[1] = 1'b0;
    step();
    busy4[1] = 1'b1;
    step();
    checks++; if (grant4 !== 4'b0100) begin errors++; $display("FAIL ar_second: got %b expected 0100", grant4); end
    repeat (9) step();
    checks++; if (hang4 !== 1'b1) begin errors++; $display("FAIL ar_hang_set: got %b expected 1", hang4); end
    reset_n_i = 1'b0;
    #1;
    checks++; if (grant4 !== 4'b0000) begin errors++; $display("FAIL ar_grant: got %b expected 0000", grant4); end
    checks++; if (ocmd4 !== e_dma_nop) begin errors++; $display("FAIL ar_cmd: got %0d expected %0d", ocmd4, e_dma_nop); end
    checks++; if (hang4 !== 1'b0) begin errors++; $display("FAIL ar_hang: got %b expected 0", hang4); end
    step();
    reset_n_i = 1'b1;
    step();
    checks++; if (grant4 !== 4'b0010) begin errors++; $display("FAIL ar_after: got %b expected 0010", grant4); end
    checks++; if (oid4 !== 2'd1) begin errors++; $display("FAIL ar_after_id: got %0d expected 1", oid4); end
  endtask

  task automatic test_non_pow2();
    logic [2:0] exp3;
    int order [4] = '{0, 1, 2, 0};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      cmd3[i] = e_dma_send_evict_data; addr3[i] = 16'h10 + 16'(i);
    end
    busy3 = 3'b111;
    for (int n = 0; n < 4; n++) begin
      exp3 = 3'b001 << order[n];
      step();
      checks++; if (grant3 !== exp3) begin errors++; $display("FAIL np2_grant_%0d: got %b expected %b", n, grant3, exp3); end
      checks++; if (oid3 !== 2'(order[n])) begin errors++; $display("FAIL np2_id_%0d: got %0d expected %0d", n, oid3, order[n]); end
      checks++; if (oaddr3 !== 16'h10 + 16'(order[n])) begin errors++; $display("FAIL np2_addr_%0d: got %h expected %h", n, oaddr3, 16'h10 + 16'(order[n])); end
      checks++; if (ocmd3 !== e_dma_send_evict_data) begin errors++; $display("FAIL np2_cmd_%0d: got %0d expected %0d", n, ocmd3, e_dma_send_evict_data); end
      busy3[order[n]] = 1'b0;
      step();
      busy3 = 3'b111;
    end
    checks++; if (hang3 !== 1'b0) begin errors++; $display("FAIL np2_hang: got %b expected 0", hang3); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_lock_hold();
    test_done_demux();
    test_watchdog();
    test_async_reset();
    test_non_pow2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
